vga_text_sched: RTL and testbench



---
 rtl/vga_text_sched_if.sv | 67 ++++++
 rtl/vga_text_sched.sv | 187 ++++++++++++++++++
 tb/tb_vga_text_sched.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_sched_if
// Description : Request handshakes and display write-port bundle for the
//               80x40 text-display write scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_text_sched_if;
    // game cell-write requester
    logic        g_valid;
    logic        g_ready;
    logic [11:0] g_addr;
    logic [7:0]  g_char;
    logic [7:0]  g_color;
    // status/score panel cell-write requester
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_addr;
    logic [7:0]  s_char;
    logic [7:0]  s_color;
    // cursor update
    logic        cur_valid;
    logic        cur_ready;
    logic [7:0]  cur_x;
    logic [7:0]  cur_y;
    // full-screen clear
    logic        clr_valid;
    logic        clr_ready;
    logic [7:0]  clr_color;
    // display write ports
    logic        wren;
    logic        wrencolor;
    logic [11:0] wraddress;
    logic [7:0]  wrdata;
    logic [7:0]  wcolor;
    logic        wrencursor;
    logic [1:0]  wcursorAddress;
    logic [7:0]  wcursor;
    // status
    logic        busy;
    logic        err;

    // requester side: drives requests, observes readys and display writes
    modport master (
        output g_valid, g_addr, g_char, g_color,
        output s_valid, s_addr, s_char, s_color,
        output cur_valid, cur_x, cur_y,
        output clr_valid, clr_color,
        input  g_ready, s_ready, cur_ready, clr_ready,
        input  wren, wrencolor, wraddress, wrdata, wcolor,
        input  wrencursor, wcursorAddress, wcursor,
        input  busy, err
    );

    // scheduler side
    modport slave (
        input  g_valid, g_addr, g_char, g_color,
        input  s_valid, s_addr, s_char, s_color,
        input  cur_valid, cur_x, cur_y,
        input  clr_valid, clr_color,
        output g_ready, s_ready, cur_ready, clr_ready,
        output wren, wrencolor, wraddress, wrdata, wcolor,
        output wrencursor, wcursorAddress, wcursor,
        output busy, err
    );
endinterface
`default_nettype wire

// File: rtl/vga_text_sched.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_sched
// Description : Single write scheduler for the vga80x40 text display.
//               Arbitrates game/status cell writes (round-robin on ties),
//               cursor updates and full-screen clear (clear > cursor > cell).
//               Optional macro VGA_TEXT_SCHED_BOUNDS_CHECK_EN drops
//               out-of-range cell writes (pulsing err) and clamps the cursor.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_text_sched #(
    parameter int         COLS     = 80,
    parameter int         ROWS     = 40,
    parameter logic [7:0] CLR_CHAR = 8'h20
) (
    input  logic              clk25MHz,
    input  logic              reset,
    vga_text_sched_if.slave   bus
);
    localparam int          CELLS       = COLS * ROWS;
    localparam logic [11:0] c_LAST_ADDR = 12'(CELLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_CUR_X = 2'd2,
        ST_CUR_Y = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_last_s, w_last_s;      // 1: status won the last cell grant
    logic [7:0]  r_cur_y, w_cur_y_nxt;    // y held for the second cursor write

    logic        r_wren, w_wren;          // drives both wren and wrencolor
    logic [11:0] r_wraddress, w_wraddress;
    logic [7:0]  r_wrdata, w_wrdata;
    logic [7:0]  r_wcolor, w_wcolor;
    logic        r_wrencursor, w_wrencursor;
    logic [1:0]  r_wcursor_addr, w_wcursor_addr;
    logic [7:0]  r_wcursor, w_wcursor;
    logic        r_err, w_err;

    logic        w_idle, w_clr_go, w_cur_go, w_cell_ok, w_g_go, w_s_go;
    logic [11:0] w_cell_addr;
    logic [7:0]  w_cell_char, w_cell_color;
    logic        w_cell_oob;
    logic [7:0]  w_cur_x, w_cur_y;

    // priority and round-robin arbitration, only meaningful while idle
    assign w_idle    = (r_state == ST_IDLE);
    assign w_clr_go  = w_idle & bus.clr_valid;
    assign w_cur_go  = w_idle & bus.cur_valid & ~bus.clr_valid;
    assign w_cell_ok = w_idle & ~bus.clr_valid & ~bus.cur_valid;
    assign w_g_go    = w_cell_ok & bus.g_valid & (~bus.s_valid | r_last_s);
    assign w_s_go    = w_cell_ok & bus.s_valid & (~bus.g_valid | ~r_last_s);

    assign w_cell_addr  = w_g_go ? bus.g_addr  : bus.s_addr;
    assign w_cell_char  = w_g_go ? bus.g_char  : bus.s_char;
    assign w_cell_color = w_g_go ? bus.g_color : bus.s_color;

`ifdef VGA_TEXT_SCHED_BOUNDS_CHECK_EN
    localparam logic [11:0] c_CELLS = 12'(CELLS);
    localparam logic [7:0]  c_MAX_X = 8'(COLS - 1);
    localparam logic [7:0]  c_MAX_Y = 8'(ROWS - 1);

    assign w_cell_oob = (w_g_go | w_s_go) & (w_cell_addr >= c_CELLS);
    assign w_cur_x    = (bus.cur_x > c_MAX_X) ? c_MAX_X : bus.cur_x;
    assign w_cur_y    = (bus.cur_y > c_MAX_Y) ? c_MAX_Y : bus.cur_y;
`else
    assign w_cell_oob = 1'b0;
    assign w_cur_x    = bus.cur_x;
    assign w_cur_y    = bus.cur_y;
`endif

    assign bus.clr_ready = w_clr_go;
    assign bus.cur_ready = w_cur_go;
    assign bus.g_ready   = w_g_go;
    assign bus.s_ready   = w_s_go;
    assign bus.busy      = ~w_idle;

    // next state and next values of the registered write ports
    always_comb begin
        w_state_nxt    = r_state;
        w_last_s       = r_last_s;
        w_cur_y_nxt    = r_cur_y;
        w_wren         = 1'b0;
        w_wraddress    = r_wraddress;
        w_wrdata       = r_wrdata;
        w_wcolor       = r_wcolor;
        w_wrencursor   = 1'b0;
        w_wcursor_addr = r_wcursor_addr;
        w_wcursor      = r_wcursor;
        w_err          = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_clr_go) begin
                    // first clear write goes out with the accept; the
                    // address register then doubles as the sweep counter
                    w_state_nxt = ST_CLEAR;
                    w_wren      = 1'b1;
                    w_wraddress = 12'd0;
                    w_wrdata    = CLR_CHAR;
                    w_wcolor    = bus.clr_color;
                end else if (w_cur_go) begin
                    w_state_nxt    = ST_CUR_X;
                    w_wrencursor   = 1'b1;
                    w_wcursor_addr = 2'd0;
                    w_wcursor      = w_cur_x;
                    w_cur_y_nxt    = w_cur_y;
                end else if (w_g_go | w_s_go) begin
                    w_last_s = w_s_go;
                    if (w_cell_oob) begin
                        w_err = 1'b1;
                    end else begin
                        w_wren      = 1'b1;
                        w_wraddress = w_cell_addr;
                        w_wrdata    = w_cell_char;
                        w_wcolor    = w_cell_color;
                    end
                end
            end
            ST_CLEAR: begin
                // the last cell is being written this cycle: stop here so
                // the counter never runs past the final cell
                if (r_wraddress == c_LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wren      = 1'b1;
                    w_wraddress = r_wraddress + 12'd1;
                end
            end
            ST_CUR_X: begin
                w_state_nxt    = ST_CUR_Y;
                w_wrencursor   = 1'b1;
                w_wcursor_addr = 2'd1;
                w_wcursor      = r_cur_y;
            end
            ST_CUR_Y: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // state register, arbitration history and registered write ports
    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_last_s       <= 1'b1;
            r_cur_y        <= 8'd0;
            r_wren         <= 1'b0;
            r_wraddress    <= 12'd0;
            r_wrdata       <= 8'd0;
            r_wcolor       <= 8'd0;
            r_wrencursor   <= 1'b0;
            r_wcursor_addr <= 2'd0;
            r_wcursor      <= 8'd0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_last_s       <= w_last_s;
            r_cur_y        <= w_cur_y_nxt;
            r_wren         <= w_wren;
            r_wraddress    <= w_wraddress;
            r_wrdata       <= w_wrdata;
            r_wcolor       <= w_wcolor;
            r_wrencursor   <= w_wrencursor;
            r_wcursor_addr <= w_wcursor_addr;
            r_wcursor      <= w_wcursor;
            r_err          <= w_err;
        end
    end

    assign bus.wren           = r_wren;
    assign bus.wrencolor      = r_wren;
    assign bus.wraddress      = r_wraddress;
    assign bus.wrdata         = r_wrdata;
    assign bus.wcolor         = r_wcolor;
    assign bus.wrencursor     = r_wrencursor;
    assign bus.wcursorAddress = r_wcursor_addr;
    assign bus.wcursor        = r_wcursor;
    // without the bounds check r_err can never be set, so err stays 0
    assign bus.err            = r_err;
endmodule
`default_nettype wire

// File: tb/tb_vga_text_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_text_sched
// Description : Directed scoreboard bench for vga_text_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_text_sched;
    localparam int COLS  = 80;
    localparam int ROWS  = 40;
    localparam int CELLS = COLS * ROWS;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    vga_text_sched_if bus();

    vga_text_sched #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .CLR_CHAR (8'h20)
    ) dut (
        .clk25MHz (clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic        is_cur;
        logic [11:0] addr;
        logic [7:0]  data;
        logic [7:0]  color;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] readys();
        return {bus.g_ready, bus.s_ready, bus.cur_ready, bus.clr_ready};
    endfunction

    function automatic void push_cell(logic [11:0] a, logic [7:0] d, logic [7:0] c);
        sb.push_back(exp_t'{1'b0, a, d, c});
    endfunction

    function automatic void push_clear(logic [7:0] c);
        for (int i = 0; i < CELLS; i++) sb.push_back(exp_t'{1'b0, 12'(i), 8'h20, c});
    endfunction

    function automatic void push_cur(logic [7:0] x, logic [7:0] y);
        sb.push_back(exp_t'{1'b1, 12'd0, x, 8'd0});
        sb.push_back(exp_t'{1'b1, 12'd1, y, 8'd0});
    endfunction

    task automatic drain();
        for (int i = 0; i < 8000 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drain", 64'(sb.size()), 64'd0);
    endtask

    // scoreboard: every display write must match the next expected entry
    always @(negedge clk) begin
        exp_t e;
        if (bus.wren === 1'b1 || bus.wrencursor === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 64'({bus.wren, bus.wrencursor}), 64'd0);
            end else begin
                e = sb.pop_front();
                if (!e.is_cur)
                    chk("cell_write",
                        {33'd0, bus.wren, bus.wrencolor, bus.wrencursor, bus.wraddress, bus.wrdata, bus.wcolor},
                        {33'd0, 3'b110, e.addr, e.data, e.color});
                else
                    chk("cursor_write",
                        {52'd0, bus.wren, bus.wrencursor, bus.wcursorAddress, bus.wcursor},
                        {52'd0, 2'b01, e.addr[1:0], e.data});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen, g_done, s_done, c_done;
        int busy_cnt, bad;

        reset = 1'b1;
        bus.g_valid = 1'b0; bus.g_addr = '0; bus.g_char = '0; bus.g_color = '0;
        bus.s_valid = 1'b0; bus.s_addr = '0; bus.s_char = '0; bus.s_color = '0;
        bus.cur_valid = 1'b0; bus.cur_x = '0; bus.cur_y = '0;
        bus.clr_valid = 1'b0; bus.clr_color = '0;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_enables", 64'({bus.wren, bus.wrencolor, bus.wrencursor}), 64'd0);
        chk("rst_wraddress", 64'(bus.wraddress), 64'd0);
        chk("rst_data_color", 64'({bus.wrdata, bus.wcolor}), 64'd0);
        chk("rst_cursor", 64'({bus.wcursorAddress, bus.wcursor}), 64'd0);
        chk("rst_busy_err", 64'({bus.busy, bus.err}), 64'd0);
        reset = 1'b0;

        // round-robin tie: G, S, G, S
        @(negedge clk);
        bus.g_valid = 1'b1; bus.g_addr = 12'd10; bus.g_char = 8'h47; bus.g_color = 8'h11;
        bus.s_valid = 1'b1; bus.s_addr = 12'd20; bus.s_char = 8'h53; bus.s_color = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_grant", 64'(readys()), (i % 2 == 0) ? 64'h8 : 64'h4);
            if (i % 2 == 0) push_cell(12'd10, 8'h47, 8'h11);
            else            push_cell(12'd20, 8'h53, 8'h22);
            @(negedge clk);
            chk("rr_back_to_back_wren", 64'(bus.wren), 64'd1);
        end
        bus.g_valid = 1'b0; bus.s_valid = 1'b0;
        drain();

        // single game write
        @(negedge clk);
        bus.g_valid = 1'b1; bus.g_addr = 12'd85; bus.g_char = 8'h41; bus.g_color = 8'hF2;
        #1;
        chk("single_ready", 64'(readys()), 64'h8);
        push_cell(12'd85, 8'h41, 8'hF2);
        @(negedge clk);
        bus.g_valid = 1'b0;
        chk("single_write", 64'({bus.wren, bus.wrencolor, bus.wraddress, bus.wrdata, bus.wcolor}),
            64'({2'b11, 12'd85, 8'h41, 8'hF2}));
        @(negedge clk);
        chk("single_idle_enables", 64'({bus.wren, bus.wrencolor}), 64'd0);

        // clear with a cursor update pending throughout
        bus.clr_valid = 1'b1; bus.clr_color = 8'h07;
        #1;
        chk("clr_ready", 64'(readys()), 64'h1);
        push_clear(8'h07);
        @(negedge clk);
        bus.clr_valid = 1'b0;
        bus.cur_valid = 1'b1; bus.cur_x = 8'd10; bus.cur_y = 8'd5;
        push_cur(8'd10, 8'd5);
        busy_cnt = 0; bad = 0; seen = 1'b0;
        for (int c = 0; c < CELLS + 10 && !seen; c++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            #1;
            if (bus.busy === 1'b1 && bus.cur_ready === 1'b1) bad++;
            seen = bus.cur_ready;
            if (!seen) @(negedge clk);
        end
        chk("clr_busy_cycles", 64'(busy_cnt), 64'(CELLS));
        chk("cur_ready_during_busy", 64'(bad), 64'd0);
        chk("cur_accept_after_clear", 64'(seen), 64'd1);
        @(negedge clk);
        bus.cur_valid = 1'b0;
        chk("cur_x_write", 64'({bus.wrencursor, bus.wcursorAddress, bus.wcursor, bus.busy}),
            64'({1'b1, 2'd0, 8'd10, 1'b1}));
        @(negedge clk);
        chk("cur_y_write", 64'({bus.wrencursor, bus.wcursorAddress, bus.wcursor}),
            64'({1'b1, 2'd1, 8'd5}));
        @(negedge clk);
        chk("cur_done_idle", 64'({bus.wrencursor, bus.busy}), 64'd0);
        drain();

        // all four requests at once: clear, then cursor, then status (game won last), then game
        @(negedge clk);
        bus.clr_valid = 1'b1; bus.clr_color = 8'h1E;
        bus.cur_valid = 1'b1; bus.cur_x = 8'd3; bus.cur_y = 8'd4;
        bus.g_valid = 1'b1; bus.g_addr = 12'd300; bus.g_char = 8'h61; bus.g_color = 8'h33;
        bus.s_valid = 1'b1; bus.s_addr = 12'd301; bus.s_char = 8'h62; bus.s_color = 8'h44;
        #1;
        chk("prio_only_clr_ready", 64'(readys()), 64'h1);
        push_clear(8'h1E);
        push_cur(8'd3, 8'd4);
        push_cell(12'd301, 8'h62, 8'h44);
        push_cell(12'd300, 8'h61, 8'h33);
        @(negedge clk);
        bus.clr_valid = 1'b0;
        g_done = 1'b0; s_done = 1'b0; c_done = 1'b0; bad = 0;
        for (int c = 0; c < CELLS + 40 && (bus.cur_valid || bus.g_valid || bus.s_valid); c++) begin
            #1;
            if ($countones(readys()) > 1) bad++;
            if (bus.cur_ready === 1'b1) c_done = 1'b1;
            if (bus.g_ready === 1'b1)   g_done = 1'b1;
            if (bus.s_ready === 1'b1)   s_done = 1'b1;
            @(negedge clk);
            if (c_done) bus.cur_valid = 1'b0;
            if (g_done) bus.g_valid = 1'b0;
            if (s_done) bus.s_valid = 1'b0;
        end
        chk("prio_single_ready", 64'(bad), 64'd0);
        chk("prio_all_accepted", 64'({bus.cur_valid, bus.g_valid, bus.s_valid}), 64'd0);
        drain();

        // out-of-range status write and out-of-range cursor
        @(negedge clk);
        bus.s_valid = 1'b1; bus.s_addr = 12'd3200; bus.s_char = 8'h58; bus.s_color = 8'h55;
        #1;
        chk("oob_ready", 64'(readys()), 64'h4);
`ifndef VGA_TEXT_SCHED_BOUNDS_CHECK_EN
        push_cell(12'd3200, 8'h58, 8'h55);
`endif
        @(negedge clk);
        bus.s_valid = 1'b0;
`ifdef VGA_TEXT_SCHED_BOUNDS_CHECK_EN
        chk("oob_no_write", 64'({bus.wren, bus.wrencolor}), 64'd0);
        chk("oob_err_pulse", 64'(bus.err), 64'd1);
`else
        chk("oob_passthrough_write", 64'({bus.wren, bus.wraddress}), 64'({1'b1, 12'd3200}));
        chk("oob_err_tied", 64'(bus.err), 64'd0);
`endif
        @(negedge clk);
        chk("err_one_cycle", 64'(bus.err), 64'd0);
        bus.cur_valid = 1'b1; bus.cur_x = 8'd90; bus.cur_y = 8'd45;
        #1;
        chk("oob_cur_ready", 64'(readys()), 64'h2);
`ifdef VGA_TEXT_SCHED_BOUNDS_CHECK_EN
        push_cur(8'd79, 8'd39);
`else
        push_cur(8'd90, 8'd45);
`endif
        @(negedge clk);
        bus.cur_valid = 1'b0;
        drain();

        // reset mid-clear at address 100
        @(negedge clk);
        bus.clr_valid = 1'b1; bus.clr_color = 8'h5A;
        #1;
        chk("rst_clr_ready", 64'(readys()), 64'h1);
        push_clear(8'h5A);
        @(negedge clk);
        bus.clr_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (bus.wren === 1'b1 && bus.wraddress === 12'd100) seen = 1'b1;
            else @(negedge clk);
        end
        chk("clear_reached_100", 64'(seen), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_enables", 64'({bus.wren, bus.wrencolor, bus.wrencursor}), 64'd0);
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        sb.delete();
        @(negedge clk);
        chk("rst_hold_enables", 64'({bus.wren, bus.wrencursor}), 64'd0);
        reset = 1'b0;
        bus.g_valid = 1'b1; bus.g_addr = 12'd5; bus.g_char = 8'h78; bus.g_color = 8'h01;
        #1;
        chk("post_rst_idle_ready", 64'(readys()), 64'h8);
        push_cell(12'd5, 8'h78, 8'h01);
        @(negedge clk);
        bus.g_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("final_quiet", 64'({bus.wren, bus.wrencursor, bus.busy}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
